ysyx_22040759_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_22040759_mem_arbiter
// PURPOSE
//   Shares the single memory bus port (into the AXI bridge) between instruction fetch (IF) and the load/store stage (MEM).
//   Fixed priority to MEM (older instruction), with a starvation guard so IF is never locked out.
//   Latches the winning request, holds it stable on the bus until bus_ack, then routes the ack/rdata back to the winner only.
//   Sits between the IF/MEM stages and the AXI bridge. Its req/ack stalls feed the same pipeline-hold path the load-use hazard logic drives.
// PARAMETERS
//   ADDR_W      64  address width
//   DATA_W      64  data width; wstrb is DATA_W/8
//   STARVE_MAX  4   consecutive MEM wins while IF waits before IF is forced to win; legal range 1..15
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous reset, active-high
//   if_req     in   1          IF read request; held until if_ack
//   if_addr    in   ADDR_W     IF fetch address
//   if_kill    in   1          IF request squashed (branch flush); suppresses the pending if_ack
//   if_ack     out  1          one-cycle pulse: IF read complete, if_rdata valid
//   if_rdata   out  DATA_W     IF read data
//   mem_req    in   1          MEM request; held until mem_ack
//   mem_we     in   1          1 = store, 0 = load
//   mem_addr   in   ADDR_W     MEM address
//   mem_wdata  in   DATA_W     store data
//   mem_wstrb  in   DATA_W/8   store byte enables
//   mem_ack    out  1          one-cycle pulse: MEM access complete, mem_rdata valid for loads
//   mem_rdata  out  DATA_W     load data
//   bus_req    out  1          transaction valid to the bridge; held high until bus_ack
//   bus_we, bus_addr, bus_wdata, bus_wstrb   out   1/ADDR_W/DATA_W/DATA_W/8   latched transaction fields
//   bus_ack    in   1          one-cycle completion from the bridge
//   bus_rdata  in   DATA_W     read data, valid with bus_ack
// BEHAVIOUR
//   Reset: state=IDLE; starve_cnt=0; kill_pend=0; all outputs 0 (bus_req, if_ack, mem_ack, data/addr buses).
//   FSM states: IDLE, BUSY_IF, BUSY_MEM.
//   IDLE: arbitration, evaluated combinationally on this cycle's requests. The result is registered.
//     - mem_req & (!if_req | starve_cnt<STARVE_MAX)  -> BUSY_MEM. Latch mem_we/addr/wdata/wstrb.
//     - if_req & !if_kill & (!mem_req | starve_cnt==STARVE_MAX)  -> BUSY_IF. Latch if_addr; bus_we=0, bus_wstrb=0.
//     - otherwise stay in IDLE.
//   bus_req=1 in both BUSY states. This gives a 1-cycle request-to-bus_req latency.
//   Bus fields are driven only from the latch and stay stable while bus_req=1, even if the requester's inputs change.
//   BUSY_x on bus_ack:
//     - x_ack pulses 1 for exactly that cycle and x_rdata=bus_rdata. x_rdata holds its value until the next ack for x.
//     - bus_req drops in the same cycle (combinational off bus_ack); state->IDLE.
//     - A 1-cycle bubble is mandatory between bus transactions. Max throughput is 1 transaction per 2 cycles plus bridge latency.
//   Starvation counter:
//     - +1 (saturating at STARVE_MAX) on each MEM grant made while if_req=1 & !if_kill.
//     - Cleared on every IF grant.
//     - Cleared when if_req=0 in IDLE.
//   if_kill while BUSY_IF:
//     - Set kill_pend. The bus transaction still completes; no abort exists on the bus.
//     - On bus_ack, if_ack is suppressed (stays 0) and kill_pend clears.
//     - if_kill in IDLE blocks an IF grant that cycle.
//   Simultaneous events:
//     - bus_ack and if_kill in the same cycle: the ack is suppressed.
//     - bus_ack and new requests in the same cycle: the requests are ignored until IDLE.
//   Protocol violation (x_req drops before x_ack): the latched transaction still completes. The ack pulse is still generated, and the requester ignores it.
//   Reset mid-transaction: the next cycle is IDLE with bus_req=0 and nothing latched. The bridge shares rst and must discard its in-flight beat.
//   bus_ack in IDLE is ignored; no ack pulse is generated.
// TESTING
//   1. Reset then if_req=1, if_addr=0x8000_0000; bus_ack 3 cycles after bus_req -> bus_req rises cycle+1; bus_addr=0x8000_0000, bus_we=0; if_ack pulses 1 cycle with if_rdata=bus_rdata.
//   2. if_req and mem_req both high in the same cycle (mem_we=1, addr 0x8000_1000, wstrb 0xFF) -> MEM granted first, mem_ack; then IF granted after a 1-cycle IDLE bubble.
//   3. Starvation, STARVE_MAX=4: mem_req held high continuously, if_req held high -> 4 MEM grants, 5th grant goes to IF, starve_cnt returns to 0.
//   4. Kill: IF granted, if_kill pulsed 1 cycle before bus_ack -> bus transaction completes, if_ack stays 0; the next IF request acks normally.
//   5. Stability: change mem_addr and mem_wdata mid-transaction -> bus_addr and bus_wdata are unchanged until bus_ack.
//   6. Sync rst asserted during BUSY_MEM -> next cycle: bus_req=0, mem_ack=0, state IDLE; a stray bus_ack in IDLE produces no ack pulse.

Source files
------------

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Arbitrates the shared memory bus between instruction fetch (IF) and load/store (MEM).
// MEM has priority; a starvation counter forces an IF grant after STARVE_MAX MEM wins.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr/if_kill      IF read request, address, flush squash
//   if_ack/if_rdata             IF completion pulse and read data
//   mem_req/we/addr/wdata/wstrb MEM request and store fields
//   mem_ack/mem_rdata           MEM completion pulse and load data
//   bus_req/we/addr/wdata/wstrb latched transaction towards the bridge
//   bus_ack/bus_rdata           bridge completion and read data
module ysyx_22040759_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_ack,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t            state, state_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic              kill_pend, kill_nxt;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;

    logic if_ok;
    logic grant_mem;
    logic grant_if;

    assign if_ok     = if_req & ~if_kill;
    assign grant_mem = mem_req & (~if_req | (starve_cnt < SMAX));
    assign grant_if  = if_ok & (~mem_req | (starve_cnt == SMAX));

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        kill_nxt   = kill_pend;
        unique case (state)
            IDLE: begin
                if (grant_mem) begin
                    state_nxt = BUSY_MEM;
                    if (if_ok && starve_cnt < SMAX)
                        starve_nxt = starve_cnt + 4'd1;
                end else if (grant_if) begin
                    state_nxt  = BUSY_IF;
                    starve_nxt = 4'd0;
                end
                if (!if_req)
                    starve_nxt = 4'd0;
            end
            BUSY_IF: begin
                // A squashed fetch still has to drain on the bus;
                // remember the kill so its ack is swallowed.
                if (bus_ack) begin
                    state_nxt = IDLE;
                    kill_nxt  = 1'b0;
                end else if (if_kill) begin
                    kill_nxt = 1'b1;
                end
            end
            BUSY_MEM: begin
                if (bus_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion is combinational off bus_ack so the requester sees
    // the pulse and data in the same cycle the bridge delivers them.
    assign bus_req   = (state != IDLE) & ~bus_ack;
    assign if_ack    = (state == BUSY_IF) & bus_ack & ~kill_pend & ~if_kill;
    assign mem_ack   = (state == BUSY_MEM) & bus_ack;
    assign if_rdata  = if_ack ? bus_rdata : if_rdata_q;
    assign mem_rdata = mem_ack ? bus_rdata : mem_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            kill_pend   <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_wstrb   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            kill_pend  <= kill_nxt;
            if (state == IDLE) begin
                if (grant_mem) begin
                    bus_we    <= mem_we;
                    bus_addr  <= mem_addr;
                    bus_wdata <= mem_wdata;
                    bus_wstrb <= mem_wstrb;
                end else if (grant_if) begin
                    bus_we    <= 1'b0;
                    bus_addr  <= if_addr;
                    bus_wdata <= '0;
                    bus_wstrb <= '0;
                end
            end
            if (if_ack)
                if_rdata_q <= bus_rdata;
            if (mem_ack)
                mem_rdata_q <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed testbench for ysyx_22040759_mem_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_ysyx_22040759_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_kill = 1'b0;
    logic        if_ack;
    logic [63:0] if_rdata;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_wstrb = '0;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [63:0] bus_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_22040759_mem_arbiter #(
        .ADDR_W(64),
        .DATA_W(64),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_bus_req got=%0h exp=0", bus_req); end
        n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL rst_if_ack got=%0h exp=0", if_ack); end
        n_cmp++; if (mem_ack !== 1'b0) begin n_bad++; $display("FAIL rst_mem_ack got=%0h exp=0", mem_ack); end
        n_cmp++; if (bus_addr !== 64'h0) begin n_bad++; $display("FAIL rst_bus_addr got=%h exp=0", bus_addr); end
        n_cmp++; if (bus_wdata !== 64'h0) begin n_bad++; $display("FAIL rst_bus_wdata got=%h exp=0", bus_wdata); end
        n_cmp++; if (if_rdata !== 64'h0) begin n_bad++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
        n_cmp++; if (mem_rdata !== 64'h0) begin n_bad++; $display("FAIL rst_mem_rdata got=%h exp=0", mem_rdata); end
    endtask

    task automatic test_if_read;
        if_req = 1'b1;
        if_addr = 64'h8000_0000;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL t1_req_early got=%0h exp=0", bus_req); end
        tick();
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL t1_bus_req got=%0h exp=1", bus_req); end
        n_cmp++; if (bus_addr !== 64'h8000_0000) begin n_bad++; $display("FAIL t1_bus_addr got=%h exp=80000000", bus_addr); end
        n_cmp++; if (bus_we !== 1'b0) begin n_bad++; $display("FAIL t1_bus_we got=%0h exp=0", bus_we); end
        n_cmp++; if (bus_wstrb !== 8'h00) begin n_bad++; $display("FAIL t1_bus_wstrb got=%h exp=00", bus_wstrb); end
        tick();
        tick();
        tick();
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL t1_req_hold got=%0h exp=1", bus_req); end
        bus_ack = 1'b1;
        bus_rdata = 64'h1122_3344_5566_7788;
        #1;
        n_cmp++; if (if_ack !== 1'b1) begin n_bad++; $display("FAIL t1_if_ack got=%0h exp=1", if_ack); end
        n_cmp++; if (if_rdata !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL t1_if_rdata got=%h exp=1122334455667788", if_rdata); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL t1_req_drop got=%0h exp=0", bus_req); end
        n_cmp++; if (mem_ack !== 1'b0) begin n_bad++; $display("FAIL t1_mem_ack got=%0h exp=0", mem_ack); end
        tick();
        bus_ack = 1'b0;
        if_req = 1'b0;
        bus_rdata = 64'hdead;
        #1;
        n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL t1_ack_pulse got=%0h exp=0", if_ack); end
        n_cmp++; if (if_rdata !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL t1_rdata_hold got=%h exp=1122334455667788", if_rdata); end
    endtask

    task automatic test_priority;
        if_req = 1'b1;
        if_addr = 64'h8000_0040;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 64'h8000_1000;
        mem_wdata = 64'hcafe_babe_0000_0001;
        mem_wstrb = 8'hff;
        tick();
        n_cmp++; if (bus_we !== 1'b1) begin n_bad++; $display("FAIL t2_bus_we got=%0h exp=1", bus_we); end
        n_cmp++; if (bus_addr !== 64'h8000_1000) begin n_bad++; $display("FAIL t2_bus_addr got=%h exp=80001000", bus_addr); end
        n_cmp++; if (bus_wstrb !== 8'hff) begin n_bad++; $display("FAIL t2_bus_wstrb got=%h exp=ff", bus_wstrb); end
        n_cmp++; if (bus_wdata !== 64'hcafe_babe_0000_0001) begin n_bad++; $display("FAIL t2_bus_wdata got=%h exp=cafebabe00000001", bus_wdata); end
        bus_ack = 1'b1;
        bus_rdata = 64'h0;
        #1;
        n_cmp++; if (mem_ack !== 1'b1) begin n_bad++; $display("FAIL t2_mem_ack got=%0h exp=1", mem_ack); end
        n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL t2_if_ack_early got=%0h exp=0", if_ack); end
        tick();
        bus_ack = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL t2_bubble got=%0h exp=0", bus_req); end
        tick();
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL t2_if_req got=%0h exp=1", bus_req); end
        n_cmp++; if (bus_addr !== 64'h8000_0040) begin n_bad++; $display("FAIL t2_if_addr got=%h exp=80000040", bus_addr); end
        n_cmp++; if (bus_we !== 1'b0) begin n_bad++; $display("FAIL t2_if_we got=%0h exp=0", bus_we); end
        bus_ack = 1'b1;
        bus_rdata = 64'h1357_9bdf;
        #1;
        n_cmp++; if (if_ack !== 1'b1) begin n_bad++; $display("FAIL t2_if_ack got=%0h exp=1", if_ack); end
        n_cmp++; if (if_rdata !== 64'h1357_9bdf) begin n_bad++; $display("FAIL t2_if_rdata got=%h exp=13579bdf", if_rdata); end
        tick();
        bus_ack = 1'b0;
        if_req = 1'b0;
        #1;
    endtask

    task automatic test_starvation;
        logic        exp_if;
        logic [63:0] exp_addr;
        logic [3:0]  exp_cnt;
        if_req = 1'b1;
        if_addr = 64'h8000_0100;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 64'h8000_2000;
        mem_wstrb = 8'h00;
        for (int g = 0; g < 5; g++) begin
            exp_if = (g == 4);
            exp_addr = exp_if ? 64'h8000_0100 : 64'h8000_2000;
            exp_cnt = exp_if ? 4'd0 : 4'(g + 1);
            tick();
            n_cmp++; if (bus_addr !== exp_addr) begin n_bad++; $display("FAIL t3_addr[%0d] got=%h exp=%h", g, bus_addr, exp_addr); end
            n_cmp++; if (dut.starve_cnt !== exp_cnt) begin n_bad++; $display("FAIL t3_cnt[%0d] got=%0d exp=%0d", g, dut.starve_cnt, exp_cnt); end
            bus_ack = 1'b1;
            bus_rdata = 64'h100 + 64'(g);
            #1;
            n_cmp++; if (if_ack !== exp_if) begin n_bad++; $display("FAIL t3_if_ack[%0d] got=%0h exp=%0h", g, if_ack, exp_if); end
            n_cmp++; if (mem_ack !== !exp_if) begin n_bad++; $display("FAIL t3_mem_ack[%0d] got=%0h exp=%0h", g, mem_ack, !exp_if); end
            tick();
            bus_ack = 1'b0;
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        #1;
    endtask

    task automatic test_kill;
        if_req = 1'b1;
        if_addr = 64'h8000_0200;
        tick();
        n_cmp++; if (bus_addr !== 64'h8000_0200) begin n_bad++; $display("FAIL t4_addr got=%h exp=80000200", bus_addr); end
        tick();
        if_kill = 1'b1;
        tick();
        if_kill = 1'b0;
        if_req = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 64'hbad0;
        #1;
        n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL t4_killed_ack got=%0h exp=0", if_ack); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL t4_req_drop got=%0h exp=0", bus_req); end
        n_cmp++; if (if_rdata !== 64'h104) begin n_bad++; $display("FAIL t4_rdata_hold got=%h exp=104", if_rdata); end
        tick();
        bus_ack = 1'b0;
        if_req = 1'b1;
        if_addr = 64'h8000_0300;
        tick();
        n_cmp++; if (bus_addr !== 64'h8000_0300) begin n_bad++; $display("FAIL t4_next_addr got=%h exp=80000300", bus_addr); end
        bus_ack = 1'b1;
        bus_rdata = 64'h600d;
        #1;
        n_cmp++; if (if_ack !== 1'b1) begin n_bad++; $display("FAIL t4_next_ack got=%0h exp=1", if_ack); end
        n_cmp++; if (if_rdata !== 64'h600d) begin n_bad++; $display("FAIL t4_next_rdata got=%h exp=600d", if_rdata); end
        tick();
        bus_ack = 1'b0;
        if_addr = 64'h8000_0400;
        tick();
        bus_ack = 1'b1;
        if_kill = 1'b1;
        #1;
        n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL t4_same_cycle got=%0h exp=0", if_ack); end
        tick();
        bus_ack = 1'b0;
        if_kill = 1'b0;
        if_req = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL t4_idle got=%0h exp=0", bus_req); end
    endtask

    task automatic test_stability;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 64'h8000_3000;
        mem_wdata = 64'h0123_4567_89ab_cdef;
        mem_wstrb = 8'h0f;
        tick();
        mem_addr = 64'h9999_0000;
        mem_wdata = 64'hffff_0000_ffff_0000;
        mem_wstrb = 8'hf0;
        mem_we = 1'b0;
        #1;
        n_cmp++; if (bus_addr !== 64'h8000_3000) begin n_bad++; $display("FAIL t5_addr got=%h exp=80003000", bus_addr); end
        n_cmp++; if (bus_wdata !== 64'h0123_4567_89ab_cdef) begin n_bad++; $display("FAIL t5_wdata got=%h exp=0123456789abcdef", bus_wdata); end
        n_cmp++; if (bus_wstrb !== 8'h0f) begin n_bad++; $display("FAIL t5_wstrb got=%h exp=0f", bus_wstrb); end
        n_cmp++; if (bus_we !== 1'b1) begin n_bad++; $display("FAIL t5_we got=%0h exp=1", bus_we); end
        tick();
        n_cmp++; if (bus_addr !== 64'h8000_3000) begin n_bad++; $display("FAIL t5_addr2 got=%h exp=80003000", bus_addr); end
        n_cmp++; if (bus_wdata !== 64'h0123_4567_89ab_cdef) begin n_bad++; $display("FAIL t5_wdata2 got=%h exp=0123456789abcdef", bus_wdata); end
        bus_ack = 1'b1;
        #1;
        n_cmp++; if (mem_ack !== 1'b1) begin n_bad++; $display("FAIL t5_mem_ack got=%0h exp=1", mem_ack); end
        tick();
        bus_ack = 1'b0;
        mem_req = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 64'h8000_4000;
        tick();
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL t6_busy got=%0h exp=1", bus_req); end
        rst = 1'b1;
        mem_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL t6_bus_req got=%0h exp=0", bus_req); end
        n_cmp++; if (mem_ack !== 1'b0) begin n_bad++; $display("FAIL t6_mem_ack got=%0h exp=0", mem_ack); end
        n_cmp++; if (bus_addr !== 64'h0) begin n_bad++; $display("FAIL t6_bus_addr got=%h exp=0", bus_addr); end
        bus_ack = 1'b1;
        bus_rdata = 64'hbeef;
        #1;
        n_cmp++; if (mem_ack !== 1'b0) begin n_bad++; $display("FAIL t6_stray_mem got=%0h exp=0", mem_ack); end
        n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL t6_stray_if got=%0h exp=0", if_ack); end
        n_cmp++; if (mem_rdata !== 64'h0) begin n_bad++; $display("FAIL t6_mem_rdata got=%h exp=0", mem_rdata); end
        tick();
        bus_ack = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL t6_still_idle got=%0h exp=0", bus_req); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_priority();
        test_starvation();
        test_kill();
        test_stability();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
